// File: rtl/t_ff_bank.sv
// rtl/t_ff_bank.sv - bank of clocked T flip-flops with hold/toggle/load/chain-count modes
// Registered change-pulse and wrap-pulse outputs align with the q update they describe.
module t_ff_bank #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] chg,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_CHAIN  = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic             tc_q, tc_d;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] chain_next;

    assign mode_sel = mode_e'(mode);

    // Masked bits pass the carry straight through, so unmasked bits form a packed counter.
    always_comb begin
        carry      = '0;
        chain_next = q_q;
        carry[0]   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            chain_next[i] = q_q[i] ^ (t[i] & carry[i]);
            carry[i+1]    = carry[i] & (q_q[i] | ~t[i]);
        end
    end

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (en) begin
            unique case (mode_sel)
                MODE_HOLD:   q_d = q_q;
                MODE_TOGGLE: q_d = q_q ^ t;
                MODE_LOAD:   q_d = d;
                MODE_CHAIN: begin
                    q_d  = chain_next;
                    tc_d = (|t) & carry[WIDTH];
                end
                default:     q_d = q_q;
            endcase
        end
        chg_d = q_d ^ q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= INIT;
            chg_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            tc_q  <= tc_d;
        end
    end

    assign q   = q_q;
    assign chg = chg_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_t_ff_bank.sv
// tb/tb_t_ff_bank.sv - self-checking bench for t_ff_bank
// Two 4-bit instances (INIT 0000 and 0110) share stimulus and are checked against a reference model.
module tb_t_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] t = 4'h0;
    logic [3:0] d = 4'h0;
    logic [3:0] q0, chg0, q1, chg1;
    logic       tc0, tc1;

    logic [3:0] mq   [2];
    logic [3:0] mchg [2];
    logic       mtc  [2];
    logic [3:0] init_v [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    t_ff_bank #(.WIDTH(4), .INIT(4'b0000)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
        .q(q0), .chg(chg0), .tc(tc0)
    );

    t_ff_bank #(.WIDTH(4), .INIT(4'b0110)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
        .q(q1), .chg(chg1), .tc(tc1)
    );

    // Chain count: gather unmasked bits into an integer, add one modulo 2^k, scatter back.
    task automatic model_step(input logic [3:0] qc, input logic e, input logic [1:0] m,
                              input logic [3:0] tt, input logic [3:0] dd,
                              output logic [3:0] qn, output logic tcn);
        int k;
        int v;
        qn  = qc;
        tcn = 1'b0;
        if (e) begin
            if (m == 2'b01) qn = qc ^ tt;
            else if (m == 2'b10) qn = dd;
            else if (m == 2'b11) begin
                k = 0;
                v = 0;
                for (int i = 0; i < 4; i++)
                    if (tt[i]) begin
                        v = v + (int'(qc[i]) << k);
                        k++;
                    end
                if (k > 0) begin
                    tcn = (v == (1 << k) - 1);
                    v = (v + 1) % (1 << k);
                    k = 0;
                    for (int i = 0; i < 4; i++)
                        if (tt[i]) begin
                            qn[i] = ((v >> k) & 1) == 1;
                            k++;
                        end
                end
            end
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] tt, input logic [3:0] dd);
        logic [3:0] qn;
        logic       tcn;
        @(negedge clk);
        rst = r; en = e; mode = m; t = tt; d = dd;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (r) begin
                mq[n] = init_v[n]; mchg[n] = 4'h0; mtc[n] = 1'b0;
            end else begin
                model_step(mq[n], e, m, tt, dd, qn, tcn);
                mchg[n] = qn ^ mq[n];
                mq[n]   = qn;
                mtc[n]  = tcn;
            end
        end
        chk4("q0", q0, mq[0]);
        chk4("chg0", chg0, mchg[0]);
        chk1("tc0", tc0, mtc[0]);
        chk4("q1", q1, mq[1]);
        chk4("chg1", chg1, mchg[1]);
        chk1("tc1", tc1, mtc[1]);
    endtask

    initial begin
        init_v[0] = 4'b0000;
        init_v[1] = 4'b0110;
        mq[0] = 4'h0; mq[1] = 4'h0;

        // reset then hold
        cyc(1'b1, 1'b1, 2'b11, 4'hF, 4'hF);
        chk4("reset_q1_init", q1, 4'b0110);
        cyc(1'b0, 1'b1, 2'b00, 4'hF, 4'hF);
        cyc(1'b0, 1'b1, 2'b00, 4'hF, 4'hF);
        chk4("hold_q0", q0, 4'b0000);

        // masked toggle
        cyc(1'b0, 1'b1, 2'b01, 4'b1010, 4'h0);
        chk4("toggle1_q0", q0, 4'b1010);
        cyc(1'b0, 1'b1, 2'b01, 4'b1010, 4'h0);
        chk4("toggle2_chg0", chg0, 4'b1010);
        cyc(1'b0, 1'b1, 2'b01, 4'b0000, 4'h0);
        chk4("toggle_t0_chg0", chg0, 4'b0000);

        // full count from 0000
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 2'b11, 4'hF, 4'h0);
            if (i < 15) chk1("count_no_tc", tc0, 1'b0);
        end
        chk4("count_wrap_q0", q0, 4'b0000);
        chk1("count_wrap_tc0", tc0, 1'b1);

        // masked chain with bit 2 frozen
        cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'b0100);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 2'b11, 4'b1011, 4'h0);
        chk4("masked_wrap_q0", q0, 4'b0100);
        chk1("masked_wrap_tc0", tc0, 1'b1);
        cyc(1'b0, 1'b1, 2'b11, 4'b0000, 4'h0);
        chk1("chain_t0_tc0", tc0, 1'b0);

        // load then disabled toggling
        cyc(1'b0, 1'b1, 2'b10, 4'hF, 4'b1001);
        cyc(1'b0, 1'b1, 2'b10, 4'hF, 4'b1001);
        chk4("reload_same_chg0", chg0, 4'b0000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'b01, 4'hF, 4'h0);
        chk4("en0_q0", q0, 4'b1001);

        // reset mid-count on the INIT=0110 instance
        cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'b1010);
        cyc(1'b0, 1'b1, 2'b11, 4'hF, 4'h0);
        chk4("pre_reset_q1", q1, 4'b1011);
        cyc(1'b1, 1'b1, 2'b11, 4'hF, 4'h0);
        chk4("mid_reset_q1", q1, 4'b0110);
        chk4("mid_reset_chg1", chg1, 4'b0000);
        cyc(1'b0, 1'b1, 2'b11, 4'hF, 4'h0);
        chk4("resume_q1", q1, 4'b0111);

        // randomized stimulus
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
